// File: rtl/digit_demux_reg.sv
// ---------------------------------------------------------------------------
// digit_demux_reg
//
// Collects a serial stream of WIDTH-bit digits into a frame of DIGITS slots
// and publishes the completed frame on a parallel output register.
//
// Digits are gathered in a shadow register while the block is in FILL.
// Accepting the last slot moves the block to a single COMMIT cycle. During
// COMMIT, in_ready is low and frame_done is high. On the edge that ends
// COMMIT, the shadow contents are copied to out_digits and out_valid is set.
// This gives a latency of two rising edges from the last accepted digit to
// out_valid. The maximum rate is one frame every DIGITS+1 cycles.
//
// Parameters
//   DIGITS      number of digit slots per frame
//   WIDTH       bits per digit
//
// Ports
//   clk         single clock; every state update happens on its rising edge
//   reset       asynchronous, active-high reset
//   in_valid    a digit is offered on in_data
//   in_data     offered digit
//   in_ready    the digit is accepted this cycle (FILL, no flush, no reset)
//   flush       synchronous discard of a partial frame (ignored in COMMIT)
//   out_ack     consumer has taken the committed frame
//   out_digits  committed frame; the first digit of a frame sits in the MSBs
//   out_valid   out_digits holds a frame that is not yet acknowledged
//   frame_done  one-cycle pulse, high during the COMMIT cycle
//   overrun     sticky flag: a commit replaced an unacknowledged frame
//   clear_err   synchronous clear of overrun (a simultaneous set wins)
// ---------------------------------------------------------------------------
module digit_demux_reg #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic                    out_ack,
  output logic [DIGITS*WIDTH-1:0] out_digits,
  output logic                    out_valid,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    clear_err
);

  // The counter needs at least one bit, even for a single-slot frame.
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(DIGITS - 1);

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [WIDTH-1:0]          shadow_reg  [DIGITS];
  logic [WIDTH-1:0]          shadow_next [DIGITS];
  logic [DIGITS*WIDTH-1:0]   shadow_flat;
  logic [DIGITS*WIDTH-1:0]   out_digits_reg, out_digits_next;
  logic                      out_valid_reg, out_valid_next;
  logic                      overrun_reg, overrun_next;
  logic                      accept;

  // in_ready is also gated by reset. The asynchronous reset already forces
  // FILL, and without this gate in_ready would read 1 while reset is held.
  assign in_ready = (state_reg == FILL) && !flush && !reset;
  assign accept   = in_valid && in_ready;

  // Slot 0 holds the first digit of a frame and maps to the most significant
  // digit of the output word.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
      assign shadow_flat[(DIGITS-1-gi)*WIDTH +: WIDTH] = shadow_reg[gi];
    end
  endgenerate

  // Next-state logic and next values for the datapath.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    out_digits_next = out_digits_reg;
    out_valid_next  = out_valid_reg;
    overrun_next    = overrun_reg;
    for (int i = 0; i < DIGITS; i++) begin
      shadow_next[i] = shadow_reg[i];
    end

    // An acknowledge with out_valid low just rewrites 0, so it has no effect.
    if (out_ack) begin
      out_valid_next = 1'b0;
    end
    if (clear_err) begin
      overrun_next = 1'b0;
    end

    case (state_reg)
      FILL: begin
        if (flush) begin
          // Drop the partial frame. in_ready is low, so the digit offered
          // in this cycle is not accepted either.
          cnt_next = '0;
          for (int i = 0; i < DIGITS; i++) begin
            shadow_next[i] = '0;
          end
        end else if (accept) begin
          shadow_next[cnt_reg] = in_data;
          if (cnt_reg == LAST_SLOT) begin
            cnt_next   = '0;
            state_next = COMMIT;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      COMMIT: begin
        // flush is ignored here. Setting out_valid and overrun takes
        // priority over a simultaneous ack or clear.
        state_next      = FILL;
        out_digits_next = shadow_flat;
        out_valid_next  = 1'b1;
        if (out_valid_reg && !out_ack) begin
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FILL;
      cnt_reg        <= '0;
      out_digits_reg <= '0;
      out_valid_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      out_digits_reg <= out_digits_next;
      out_valid_reg  <= out_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shadow
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_reg[gi] <= '0;
        end else begin
          shadow_reg[gi] <= shadow_next[gi];
        end
      end
    end
  endgenerate

  assign out_digits = out_digits_reg;
  assign out_valid  = out_valid_reg;
  assign overrun    = overrun_reg;
  // frame_done is decoded from the state, so it is low during reset.
  assign frame_done = (state_reg == COMMIT);

endmodule

// File: tb/tb_digit_demux_reg.sv
// ---------------------------------------------------------------------------
// tb_digit_demux_reg
//
// Directed testbench for digit_demux_reg with DIGITS=4 and WIDTH=4.
// The inputs change 2 ns after a rising edge. The registered outputs are read
// at that point. Combinational outputs are read after a further short settle.
// ---------------------------------------------------------------------------
module tb_digit_demux_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_ack;
  logic [15:0] out_digits;
  logic        out_valid;
  logic        frame_done;
  logic        overrun;
  logic        clear_err;

  int total;
  int bad;
  int fd_cnt;

  digit_demux_reg #(
    .DIGITS(4),
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ack   (out_ack),
    .out_digits(out_digits),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .overrun   (overrun),
    .clear_err (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock and count any frame_done pulse seen after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (frame_done) fd_cnt++;
  endtask

  task automatic push(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send four digits. On return the DUT is in its COMMIT cycle.
  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    push(a);
    push(b);
    push(c);
    push(d);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    fd_cnt    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ack   = 1'b0;
    clear_err = 1'b0;

    // Reset state.
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_digits", out_digits, 16'h0000);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic frame with in_valid held through the COMMIT cycle.
    fd_cnt   = 0;
    in_valid = 1'b1;
    in_data  = 4'h1; tick();
    in_data  = 4'h2; tick();
    in_data  = 4'h3; tick();
    in_data  = 4'h4; tick();
    check("basic_commit_in_ready", in_ready, 0);
    check("basic_commit_frame_done", frame_done, 1);
    check("basic_commit_valid_not_yet", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("basic_out_valid", out_valid, 1);
    check("basic_out_digits", out_digits, 16'h1234);
    check("basic_frame_done_low", frame_done, 0);
    check("basic_in_ready_back", in_ready, 1);
    check("basic_one_pulse", fd_cnt, 1);

    // Acknowledge handling.
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    check("ack1_valid", out_valid, 0);
    check("ack1_digits_kept", out_digits, 16'h1234);
    send4(4'hA, 4'hB, 4'hC, 4'hD);
    tick();
    check("abcd_digits", out_digits, 16'hABCD);
    check("abcd_valid", out_valid, 1);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    check("abcd_ack_valid", out_valid, 0);
    check("abcd_ack_digits", out_digits, 16'hABCD);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    check("idle_ack_valid", out_valid, 0);
    check("idle_ack_overrun", overrun, 0);

    // Overrun: a frame committed while the previous one is unacknowledged.
    send4(4'h1, 4'h2, 4'h3, 4'h4);
    tick();
    check("ovr_first_valid", out_valid, 1);
    check("ovr_first_no_err", overrun, 0);
    send4(4'h5, 4'h6, 4'h7, 4'h8);
    tick();
    check("ovr_digits", out_digits, 16'h5678);
    check("ovr_flag", overrun, 1);
    idle(3);
    check("ovr_sticky", overrun, 1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("ovr_cleared", overrun, 0);
    check("ovr_valid_kept", out_valid, 1);
    // Set beats clear in the same cycle.
    send4(4'h9, 4'h9, 4'h9, 4'h9);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("set_wins_overrun", overrun, 1);
    check("set_wins_digits", out_digits, 16'h9999);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("reclear_overrun", overrun, 0);
    // Ack during COMMIT: the new frame stays valid and there is no overrun.
    send4(4'h2, 4'h4, 4'h6, 4'h8);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    check("ack_in_commit_valid", out_valid, 1);
    check("ack_in_commit_digits", out_digits, 16'h2468);
    check("ack_in_commit_overrun", overrun, 0);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    check("ack_2468_valid", out_valid, 0);

    // Flush drops a partial frame and the digit offered with it.
    push(4'h9);
    push(4'h8);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h7;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid_kept", out_valid, 0);
    check("flush_digits_kept", out_digits, 16'h2468);
    send4(4'h1, 4'h2, 4'h3, 4'h4);
    check("flush_commit_pulse", frame_done, 1);
    tick();
    check("flush_then_digits", out_digits, 16'h1234);
    check("flush_then_valid", out_valid, 1);
    // Flush in COMMIT is ignored. The previous frame is unacknowledged, so
    // this commit also raises overrun.
    send4(4'h3, 4'h1, 4'h4, 4'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("commit_flush_digits", out_digits, 16'h3141);
    check("commit_flush_valid", out_valid, 1);
    check("commit_flush_overrun", overrun, 1);

    // Asynchronous reset pulsed between edges in the middle of a frame.
    push(4'h5);
    push(4'h6);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_digits", out_digits, 16'h0000);
    check("arst_overrun", overrun, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_frame_done", frame_done, 0);
    reset = 1'b0;
    send4(4'h4, 4'h3, 4'h2, 4'h1);
    tick();
    check("arst_after_digits", out_digits, 16'h4321);
    check("arst_after_valid", out_valid, 1);
    check("arst_after_overrun", overrun, 0);
    out_ack = 1'b1; tick(); out_ack = 1'b0;

    // Gapped input: three idle cycles between digits.
    fd_cnt = 0;
    push(4'hE); idle(3);
    check("gap_in_ready_idle", in_ready, 1);
    push(4'hF); idle(3);
    push(4'h0); idle(3);
    check("gap_valid_before", out_valid, 0);
    push(4'h1);
    tick();
    idle(3);
    check("gap_digits", out_digits, 16'hEF01);
    check("gap_valid", out_valid, 1);
    check("gap_one_pulse", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
